top: RTL and testbench
======================

TOP -- requirements
Module: top

Interface
REQ-001 The module SHALL have parameter KEY_CNT_MAX, default 20, meaning consecutive high cycles needed to accept a button press (>=1).
REQ-002 The module SHALL have parameter RT_CNT_MAX, default 2, meaning wrong-code retries permitted after the first failure (>=0).
REQ-003 The module SHALL have port clk, input, 1, the single clock; all logic rising-edge.
REQ-004 The module SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-005 The module SHALL have ports wait_t, setup, ready, fire, sure, confirm, input, 1 each, raw level buttons.
REQ-006 The module SHALL have port A, input, 4, digit value for code entry.
REQ-007 The module SHALL have port sel, output, 4, thermometer of digits entered (bit i = digit i stored).
REQ-008 The module SHALL have ports lt (locked), bt (blast trigger), rt (retry pending), m_disp (code-entry mode), output, 1 each.

Function
REQ-009 Each button SHALL produce one press pulse when high for exactly KEY_CNT_MAX consecutive cycles; no further pulse until it has been low for at least one cycle.
REQ-010 A press is acted on at the rising edge after its pulse; simultaneous presses SHALL have priority wait_t > setup > ready > fire > confirm > sure.
REQ-011 States SHALL be IDLE, SETUP, ARMED, ENTRY, BLAST, LOCKED.
REQ-012 IDLE: setup -> SETUP (digit count cleared); ready -> ARMED only if a code has been committed, else stay IDLE.
REQ-013 SETUP/ENTRY: confirm SHALL store A as the next digit (max 4; extra confirms ignored) and increment digit count.
REQ-014 SETUP: sure with 4 digits SHALL commit the code, mark code valid, clear retry count, go IDLE; sure with <4 digits ignored.
REQ-015 ARMED: fire -> ENTRY with digit count cleared.
REQ-016 ENTRY: sure with 4 digits compares to committed code; match -> BLAST; mismatch -> failure count +1, digit count cleared; if failures > RT_CNT_MAX -> LOCKED, else stay ENTRY.
REQ-017 wait_t SHALL return SETUP, ARMED, ENTRY to IDLE, clear digit count, keep committed code and failure count.
REQ-018 BLAST and LOCKED SHALL be exited only by rst.
REQ-019 Outputs registered: bt=1 only in BLAST; lt=1 only in LOCKED; rt=1 in ENTRY when failure count >0; m_disp=1 in SETUP or ENTRY; sel=thermometer of digit count in SETUP/ENTRY, 0 otherwise.

Reset
REQ-020 rst SHALL force IDLE, code invalid, stored digits 0, failure and digit counts 0, debounce counters 0, all outputs 0; rst mid-entry discards partial input.

Configuration
REQ-021 With DIGIT_CHECK_EN defined, confirm with A>9 SHALL be ignored (no store, no count); without it, any 4-bit value is stored.

Structure
REQ-022 Shared package top_pkg SHALL hold the state enum, CODE_LEN=4 and the digit type.
REQ-023 Debounce SHALL be sub-module key_debounce (parameter KEY_CNT_MAX), instantiated once per button.

Verification
REQ-024 KEY_CNT_MAX=3: ready high 1 cycle, low, high 3 cycles -> exactly one press pulse; IDLE with no code -> state stays IDLE, all outputs 0.
REQ-025 setup, confirm A=1,2,3,4 -> sel 0001,0011,0111,1111, m_disp=1; sure -> IDLE, m_disp=0, sel=0.
REQ-026 Code 1234 committed, ready, fire, enter 1234, sure -> bt=1; wait_t ignored; rst -> bt=0.
REQ-027 RT_CNT_MAX=1, code 1234: enter 0000 sure -> rt=1, ENTRY; enter 9999 sure -> lt=1, rt=0.
REQ-028 DIGIT_CHECK_EN defined, SETUP, confirm A=12 -> sel unchanged 0000; A=5 -> sel 0001.
REQ-029 confirm and sure pulses same cycle in SETUP with 3 digits -> digit stored, sure ignored, sel=1111, still SETUP.

Source files
------------

// File: rtl/top_pkg.sv
// Shared types for the code-lock controller: FSM states, decoded button commands,
// code length and the digit type.
package top_pkg;

   localparam int CODE_LEN = 4;

   typedef logic [3:0] digit_t;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      ARMED,
      ENTRY,
      BLAST,
      LOCKED
   } state_t;

   typedef enum logic [2:0] {
      CMD_NONE,
      CMD_WAIT,
      CMD_SETUP,
      CMD_READY,
      CMD_FIRE,
      CMD_CONFIRM,
      CMD_SURE
   } cmd_t;

   // Thermometer code: bit i set when more than i digits have been entered.
   function automatic logic [CODE_LEN-1:0] therm(input logic [2:0] n);
      logic [CODE_LEN-1:0] t;
      for (int i = 0; i < CODE_LEN; i++) begin
         t[i] = (int'(n) > i);
      end
      return t;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Button debounce: emits a single-cycle press pulse after the key has been high for
// exactly KEY_CNT_MAX consecutive cycles, then stays quiet until the key drops.
module key_debounce
   import top_pkg::*;
#(
   parameter int KEY_CNT_MAX = 20
) (
   input  logic clk,
   input  logic rst,
   input  logic key,
   output logic pulse
);

   localparam int CW = $clog2(KEY_CNT_MAX + 1);

   logic [CW-1:0] cnt;

   // Counter saturates at KEY_CNT_MAX so a held key produces only one pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= '0;
         pulse <= 1'b0;
      end else if (!key) begin
         cnt   <= '0;
         pulse <= 1'b0;
      end else if (cnt != CW'(KEY_CNT_MAX)) begin
         cnt   <= cnt + 1'b1;
         pulse <= (cnt == CW'(KEY_CNT_MAX - 1));
      end else begin
         pulse <= 1'b0;
      end
   end

endmodule

// File: rtl/top.sv
// Code-lock / blast controller: debounced buttons drive a setup / arm / entry FSM.
// Define DIGIT_CHECK_EN to reject confirmed digits above 9.
module top
   import top_pkg::*;
#(
   parameter int KEY_CNT_MAX = 20,
   parameter int RT_CNT_MAX  = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wait_t,
   input  logic       setup,
   input  logic       ready,
   input  logic       fire,
   input  logic       sure,
   input  logic       confirm,
   input  logic [3:0] A,
   output logic [3:0] sel,
   output logic       lt,
   output logic       bt,
   output logic       rt,
   output logic       m_disp
);

   localparam int FW = $clog2(RT_CNT_MAX + 2);

   logic p_wait, p_setup, p_ready, p_fire, p_sure, p_confirm;

   key_debounce #(.KEY_CNT_MAX(KEY_CNT_MAX)) u_wait    (.clk(clk), .rst(rst), .key(wait_t),  .pulse(p_wait));
   key_debounce #(.KEY_CNT_MAX(KEY_CNT_MAX)) u_setup   (.clk(clk), .rst(rst), .key(setup),   .pulse(p_setup));
   key_debounce #(.KEY_CNT_MAX(KEY_CNT_MAX)) u_ready   (.clk(clk), .rst(rst), .key(ready),   .pulse(p_ready));
   key_debounce #(.KEY_CNT_MAX(KEY_CNT_MAX)) u_fire    (.clk(clk), .rst(rst), .key(fire),    .pulse(p_fire));
   key_debounce #(.KEY_CNT_MAX(KEY_CNT_MAX)) u_sure    (.clk(clk), .rst(rst), .key(sure),    .pulse(p_sure));
   key_debounce #(.KEY_CNT_MAX(KEY_CNT_MAX)) u_confirm (.clk(clk), .rst(rst), .key(confirm), .pulse(p_confirm));

   state_t                    state, state_n;
   logic [2:0]                dcnt, dcnt_n;
   logic [FW-1:0]             fail_cnt, fail_n;
   logic                      code_vld, code_vld_n;
   digit_t [CODE_LEN-1:0]     ent, ent_n;
   digit_t [CODE_LEN-1:0]     code, code_n;
   cmd_t                      cmd;
   logic                      digit_ok;

`ifdef DIGIT_CHECK_EN
   assign digit_ok = (A <= 4'd9);
`else
   assign digit_ok = 1'b1;
`endif

   // Only the highest-priority press of a cycle is acted on.
   always_comb begin
      cmd = CMD_NONE;
      if (p_wait)         cmd = CMD_WAIT;
      else if (p_setup)   cmd = CMD_SETUP;
      else if (p_ready)   cmd = CMD_READY;
      else if (p_fire)    cmd = CMD_FIRE;
      else if (p_confirm) cmd = CMD_CONFIRM;
      else if (p_sure)    cmd = CMD_SURE;
   end

   always_comb begin
      state_n    = state;
      dcnt_n     = dcnt;
      fail_n     = fail_cnt;
      code_vld_n = code_vld;
      ent_n      = ent;
      code_n     = code;
      case (state)
         IDLE: begin
            if (cmd == CMD_SETUP) begin
               state_n = SETUP;
               dcnt_n  = '0;
            end else if (cmd == CMD_READY && code_vld) begin
               state_n = ARMED;
            end
         end
         ARMED: begin
            if (cmd == CMD_WAIT) begin
               state_n = IDLE;
               dcnt_n  = '0;
            end else if (cmd == CMD_FIRE) begin
               state_n = ENTRY;
               dcnt_n  = '0;
            end
         end
         SETUP, ENTRY: begin
            if (cmd == CMD_WAIT) begin
               state_n = IDLE;
               dcnt_n  = '0;
            end else if (cmd == CMD_CONFIRM && digit_ok && dcnt < 3'(CODE_LEN)) begin
               ent_n[dcnt[1:0]] = A;
               dcnt_n           = dcnt + 3'd1;
            end else if (cmd == CMD_SURE && dcnt == 3'(CODE_LEN)) begin
               if (state == SETUP) begin
                  code_n     = ent;
                  code_vld_n = 1'b1;
                  fail_n     = '0;
                  dcnt_n     = '0;
                  state_n    = IDLE;
               end else if (ent == code) begin
                  state_n = BLAST;
               end else begin
                  fail_n = fail_cnt + 1'b1;
                  dcnt_n = '0;
                  if (int'(fail_cnt) + 1 > RT_CNT_MAX) state_n = LOCKED;
               end
            end
         end
         default: ;
      endcase
   end

   // Outputs are registered from the next-state values so they line up with state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         dcnt     <= '0;
         fail_cnt <= '0;
         code_vld <= 1'b0;
         ent      <= '0;
         code     <= '0;
         sel      <= '0;
         lt       <= 1'b0;
         bt       <= 1'b0;
         rt       <= 1'b0;
         m_disp   <= 1'b0;
      end else begin
         state    <= state_n;
         dcnt     <= dcnt_n;
         fail_cnt <= fail_n;
         code_vld <= code_vld_n;
         ent      <= ent_n;
         code     <= code_n;
         bt       <= (state_n == BLAST);
         lt       <= (state_n == LOCKED);
         rt       <= (state_n == ENTRY) && (fail_n != '0);
         m_disp   <= (state_n == SETUP) || (state_n == ENTRY);
         sel      <= ((state_n == SETUP) || (state_n == ENTRY)) ? therm(dcnt_n) : '0;
      end
   end

endmodule

// File: tb/tb_top.sv
// Directed bench for the code-lock controller, built with short debounce and one retry.
module tb_top;
   import top_pkg::*;

   localparam int KCM = 3;
   localparam logic [5:0] B_WAIT  = 6'b000001;
   localparam logic [5:0] B_SETUP = 6'b000010;
   localparam logic [5:0] B_READY = 6'b000100;
   localparam logic [5:0] B_FIRE  = 6'b001000;
   localparam logic [5:0] B_SURE  = 6'b010000;
   localparam logic [5:0] B_CONF  = 6'b100000;

   logic       clk;
   logic       rst;
   logic [5:0] btn;
   logic [3:0] A;
   logic [3:0] sel;
   logic       lt, bt, rt, m_disp;

   int n_chk = 0;
   int n_err = 0;
   int pulses = 0;
   int p0;

   top #(.KEY_CNT_MAX(KCM), .RT_CNT_MAX(1)) dut (
      .clk(clk), .rst(rst),
      .wait_t(btn[0]), .setup(btn[1]), .ready(btn[2]), .fire(btn[3]),
      .sure(btn[4]), .confirm(btn[5]),
      .A(A), .sel(sel), .lt(lt), .bt(bt), .rt(rt), .m_disp(m_disp)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (dut.u_ready.pulse) pulses <= pulses + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] outs();
      return {24'd0, sel, lt, bt, rt, m_disp};
   endfunction

   function automatic logic [31:0] e(input logic [3:0] s, input logic l, input logic b,
                                     input logic r, input logic m);
      return {24'd0, s, l, b, r, m};
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      btn = '0;
      A   = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic press(input logic [5:0] b, input logic [3:0] a);
      A   = a;
      btn = b;
      repeat (KCM) @(posedge clk);
      #1 btn = '0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic enter4(input logic [3:0] d0, input logic [3:0] d1,
                         input logic [3:0] d2, input logic [3:0] d3);
      press(B_CONF, d0);
      press(B_CONF, d1);
      press(B_CONF, d2);
      press(B_CONF, d3);
   endtask

   initial begin
      clk = 1'b0;
      rst = 1'b0;
      btn = '0;
      A   = '0;
      #1;
      do_reset();
      chk("rst_outs", outs(), e(4'h0, 0, 0, 0, 0));
      chk("rst_state", 32'(dut.state), 32'(IDLE));

      // short glitch then a valid press: one pulse, no code so IDLE stays
      p0 = pulses;
      btn = B_READY;
      @(posedge clk);
      #1 btn = '0;
      @(posedge clk);
      #1 btn = B_READY;
      repeat (KCM) @(posedge clk);
      #1 btn = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("deb_one_pulse", 32'(pulses - p0), 32'd1);
      chk("nocode_state", 32'(dut.state), 32'(IDLE));
      chk("nocode_outs", outs(), e(4'h0, 0, 0, 0, 0));

      p0 = pulses;
      btn = B_READY;
      repeat (9) @(posedge clk);
      #1 btn = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("deb_hold_pulse", 32'(pulses - p0), 32'd1);

      // code setup 1234, fifth confirm ignored
      press(B_SETUP, 4'd0);
      chk("setup_enter", outs(), e(4'h0, 0, 0, 0, 1));
      press(B_CONF, 4'd1);
      chk("setup_d1", outs(), e(4'h1, 0, 0, 0, 1));
      press(B_CONF, 4'd2);
      chk("setup_d2", outs(), e(4'h3, 0, 0, 0, 1));
      press(B_CONF, 4'd3);
      chk("setup_d3", outs(), e(4'h7, 0, 0, 0, 1));
      press(B_CONF, 4'd4);
      chk("setup_d4", outs(), e(4'hF, 0, 0, 0, 1));
      press(B_CONF, 4'd5);
      chk("setup_extra", outs(), e(4'hF, 0, 0, 0, 1));
      press(B_SURE, 4'd0);
      chk("setup_commit", outs(), e(4'h0, 0, 0, 0, 0));
      chk("setup_commit_st", 32'(dut.state), 32'(IDLE));

      press(B_READY, 4'd0);
      chk("armed_state", 32'(dut.state), 32'(ARMED));
      chk("armed_outs", outs(), e(4'h0, 0, 0, 0, 0));
      press(B_FIRE, 4'd0);
      chk("entry_outs", outs(), e(4'h0, 0, 0, 0, 1));
      press(B_SURE, 4'd0);
      chk("entry_short_sure", 32'(dut.state), 32'(ENTRY));

      enter4(4'd0, 4'd0, 4'd0, 4'd0);
      chk("entry_4dig", outs(), e(4'hF, 0, 0, 0, 1));
      press(B_SURE, 4'd0);
      chk("entry_fail1", outs(), e(4'h0, 0, 0, 1, 1));
      chk("entry_fail1_st", 32'(dut.state), 32'(ENTRY));

      press(B_WAIT, 4'd0);
      chk("wait_idle", outs(), e(4'h0, 0, 0, 0, 0));
      chk("wait_idle_st", 32'(dut.state), 32'(IDLE));
      press(B_READY, 4'd0);
      press(B_FIRE, 4'd0);
      chk("reentry_rt_kept", outs(), e(4'h0, 0, 0, 1, 1));

      enter4(4'd1, 4'd2, 4'd3, 4'd4);
      press(B_SURE, 4'd0);
      chk("blast_outs", outs(), e(4'h0, 0, 1, 0, 0));
      chk("blast_state", 32'(dut.state), 32'(BLAST));
      press(B_WAIT, 4'd0);
      chk("blast_wait", outs(), e(4'h0, 0, 1, 0, 0));
      press(B_SETUP, 4'd0);
      chk("blast_setup", 32'(dut.state), 32'(BLAST));
      do_reset();
      chk("blast_rst", outs(), e(4'h0, 0, 0, 0, 0));

      // simultaneous confirm+sure with 3 digits: confirm wins
      press(B_SETUP, 4'd0);
      press(B_CONF, 4'd1);
      press(B_CONF, 4'd2);
      press(B_CONF, 4'd3);
      press(B_CONF | B_SURE, 4'd4);
      chk("prio_outs", outs(), e(4'hF, 0, 0, 0, 1));
      chk("prio_state", 32'(dut.state), 32'(SETUP));
      press(B_SURE, 4'd0);
      chk("prio_commit", 32'(dut.state), 32'(IDLE));

      // retry exhaustion
      press(B_READY, 4'd0);
      press(B_FIRE, 4'd0);
      enter4(4'd0, 4'd0, 4'd0, 4'd0);
      press(B_SURE, 4'd0);
      chk("lock_fail1", outs(), e(4'h0, 0, 0, 1, 1));
      enter4(4'd9, 4'd9, 4'd9, 4'd9);
      press(B_SURE, 4'd0);
      chk("lock_outs", outs(), e(4'h0, 1, 0, 0, 0));
      chk("lock_state", 32'(dut.state), 32'(LOCKED));
      press(B_WAIT, 4'd0);
      chk("lock_wait", outs(), e(4'h0, 1, 0, 0, 0));
      do_reset();
      chk("lock_rst", outs(), e(4'h0, 0, 0, 0, 0));

      // digit range check
      press(B_SETUP, 4'd0);
      press(B_CONF, 4'd12);
`ifdef DIGIT_CHECK_EN
      chk("digit_12", outs(), e(4'h0, 0, 0, 0, 1));
      press(B_CONF, 4'd5);
      chk("digit_5", outs(), e(4'h1, 0, 0, 0, 1));
`else
      chk("digit_12", outs(), e(4'h1, 0, 0, 0, 1));
      press(B_CONF, 4'd5);
      chk("digit_5", outs(), e(4'h3, 0, 0, 0, 1));
`endif

      // reset mid-entry discards everything
      do_reset();
      chk("midrst_outs", outs(), e(4'h0, 0, 0, 0, 0));
      press(B_READY, 4'd0);
      chk("midrst_ready", 32'(dut.state), 32'(IDLE));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
